mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
Parametrised successor to the N-state enable counter. Counts modulo MODULUS in either direction, with synchronous load, synchronous clear, wrap or saturate at the bounds, a terminal-count pulse and a sticky overflow flag. Used as the general tick/state counter behind PLL-derived clocks, LED sequencers and timebase dividers on the board.

Parameters:
MODULUS, 16, number of count states (0 .. MODULUS-1); legal range 2 .. 2**16.
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bound instead of wrapping.
PRESCALE, 4, enable-qualifier divide ratio; used only when COUNTER_PRESCALE_EN is defined; legal range >= 1.
Derived: W = $clog2(MODULUS), the width of counter_out and load_value.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
enable  in  1  count qualifier; high = count this cycle.
up_dn  in  1  direction: 1 = up, 0 = down.
clear  in  1  synchronous clear to 0.
load  in  1  synchronous load of load_value.
load_value  in  W  value loaded when load is high.
counter_out  out  W  registered count value.
tc  out  1  registered one-cycle terminal-count pulse.
ovf  out  1  registered sticky flag; set on any wrap or saturate-block event.

Behaviour:
- Reset (rst_n=0, asynchronous): counter_out=0, tc=0, ovf=0, prescaler=0. Held for as long as rst_n is low. Deassertion is taken synchronously by the board-level reset synchroniser, not inside this block.
- Per-edge priority: clear > load > count > hold.
- clear=1: counter_out<=0, ovf<=0, tc<=0, prescaler<=0.
- load=1 (clear=0): counter_out<=load_value, clamped to MODULUS-1 if load_value >= MODULUS. tc<=0. ovf unchanged.
- Count step: taken when enable=1 and clear=0 and load=0 (and the prescaler strobe is high, if that feature is built). Direction is set by up_dn.
- Up, count < MODULUS-1: count+1.
- Up, count = MODULUS-1, SATURATE=0: wraps to 0, tc<=1, ovf<=1.
- Up, count = MODULUS-1, SATURATE=1: holds at MODULUS-1, tc<=1, ovf<=1.
- Down, count > 0: count-1.
- Down, count = 0, SATURATE=0: wraps to MODULUS-1, tc<=1, ovf<=1.
- Down, count = 0, SATURATE=1: holds at 0, tc<=1, ovf<=1.
- tc is 1 only in the cycle after a boundary event. It is 0 on every other step and on hold.
- In saturate mode, tc re-pulses on every enabled step blocked at the bound.
- Arithmetic is done at W+1 bits. A non-power-of-two MODULUS never shows a value >= MODULUS.
- Latency: counter_out reflects the control inputs 1 cycle after the sampling edge.
- up_dn may change every cycle. The new direction applies on the next counted step.
- clear and load together: clear wins.
- enable low: counter_out, tc (forced 0) and ovf hold.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an internal counter of $clog2(PRESCALE) bits (minimum 1 bit) advances only while enable=1. It produces a strobe on every PRESCALE-th enabled cycle, and count steps occur only on that strobe.
- The prescaler resets to 0 on rst_n, clear and load.
- PRESCALE=1 behaves exactly like the feature-off build.
- Not defined: no prescaler logic is built. Every enabled cycle is a count step, and PRESCALE is ignored.

Test Plan:
- MODULUS=10, SATURATE=0, up: hold rst_n=0 for 4 cycles with enable=1, then release. Required: counter_out=0 during reset, then 1..9, 0, with tc=1 exactly one cycle after 9->0, and ovf=1 from then on.
- MODULUS=10, down from reset with enable=1. Required: 0 -> 9 -> 8 ... with tc on the 0->9 step. Then drop enable for 5 cycles and check counter_out holds and tc=0.
- MODULUS=10, SATURATE=1, up, 15 enabled cycles. Required: counter_out sticks at 9 and tc pulses on every blocked step. Then flip up_dn=0 and check 8, 7, ...
- MODULUS=10, load_value=12. Required: counter_out=9 (clamp). Then assert load=1 and clear=1 together with load_value=5 and check counter_out=0 and ovf=0 next cycle.
- Drive rst_n low asynchronously mid-count, away from any clock edge, at counter_out=6. Required: counter_out, tc and ovf go to 0 immediately, and counting restarts from 0 after release.
- COUNTER_PRESCALE_EN build with PRESCALE=4, MODULUS=16, up, enable=1 for 20 cycles. Required: counter_out=5, stepping once every 4 cycles. A load mid-sequence restarts the 4-cycle spacing.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter: sync clear/load, wrap or saturate, tc pulse, sticky ovf.
// Optional enable prescaler built only when COUNTER_PRESCALE_EN is defined.
module mod_updown_counter #(
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4,
  localparam int W       = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         up_dn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] counter_out,
  output logic         tc,
  output logic         ovf
);

  localparam int         W1    = W + 1;
  localparam logic [W:0] MAX_V = W1'(MODULUS - 1);

  logic [W:0] cnt_ext, ld_ext, ld_clamp, nxt_ext;
  logic       bound, strobe;
  logic       unused_hi;

  assign cnt_ext   = {1'b0, counter_out};
  assign ld_ext    = {1'b0, load_value};
  assign ld_clamp  = (ld_ext > MAX_V) ? MAX_V : ld_ext;
  assign unused_hi = nxt_ext[W] ^ ld_clamp[W];

  // Extra headroom bit keeps the bound compare exact for non-power-of-two MODULUS.
  always_comb begin
    nxt_ext = cnt_ext;
    bound   = 1'b0;
    if (up_dn) begin
      if (cnt_ext >= MAX_V) begin
        bound   = 1'b1;
        nxt_ext = (SATURATE != 0) ? MAX_V : '0;
      end else begin
        nxt_ext = cnt_ext + W1'(1);
      end
    end else begin
      if (cnt_ext == '0) begin
        bound   = 1'b1;
        nxt_ext = (SATURATE != 0) ? '0 : MAX_V;
      end else begin
        nxt_ext = cnt_ext - W1'(1);
      end
    end
  end

`ifdef COUNTER_PRESCALE_EN
  localparam int          PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Strobe on the PRESCALE-th enabled cycle; load and clear restart the spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_cnt <= '0;
    else if (clear || load)
      pre_cnt <= '0;
    else if (enable)
      pre_cnt <= (pre_cnt == PLAST) ? '0 : pre_cnt + PW'(1);
  end

  assign strobe = enable && (pre_cnt == PLAST);
`else
  localparam int PRESCALE_UNUSED = PRESCALE;
  assign strobe = enable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_out <= '0;
      tc          <= 1'b0;
      ovf         <= 1'b0;
    end else if (clear) begin
      counter_out <= '0;
      tc          <= 1'b0;
      ovf         <= 1'b0;
    end else if (load) begin
      counter_out <= ld_clamp[W-1:0];
      tc          <= 1'b0;
    end else if (strobe) begin
      counter_out <= nxt_ext[W-1:0];
      tc          <= bound;
      if (bound) ovf <= 1'b1;
    end else begin
      tc          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: wrap and saturate instances at MODULUS=10,
// plus a MODULUS=16/PRESCALE=4 instance when COUNTER_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, ovf_w, tc_s, ovf_s, tc_p, ovf_p;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.MODULUS(10), .SATURATE(0), .PRESCALE(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .counter_out(cnt_w), .tc(tc_w), .ovf(ovf_w));

  mod_updown_counter #(.MODULUS(10), .SATURATE(1), .PRESCALE(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .counter_out(cnt_s), .tc(tc_s), .ovf(ovf_s));

  mod_updown_counter #(.MODULUS(16), .SATURATE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .counter_out(cnt_p), .tc(tc_p), .ovf(ovf_p));

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 1'b0; clear = 1'b0; load = 1'b0; up_dn = 1'b1; load_value = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({cnt_w, tc_w, ovf_w} !== 6'b0000_0_0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got cnt=%0d tc=%b ovf=%b want 0/0/0", i, cnt_w, tc_w, ovf_w);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp = {4'(i % 10), (i == 10), (i >= 10)};
      checks++;
      if ({cnt_w, tc_w, ovf_w} !== exp) begin
        failures++;
        $display("FAIL wrap_up step=%0d got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=%b",
                 i, cnt_w, tc_w, ovf_w, exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_down();
    logic [3:0] exp_cnt [3] = '{4'd9, 4'd8, 4'd7};
    apply_reset();
    enable = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({cnt_w, tc_w, ovf_w} !== {exp_cnt[i], (i == 0), 1'b1}) begin
        failures++;
        $display("FAIL wrap_down step=%0d got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=1",
                 i, cnt_w, tc_w, ovf_w, exp_cnt[i], (i == 0));
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({cnt_w, tc_w, ovf_w} !== {4'd7, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL enable_hold cyc=%0d got cnt=%0d tc=%b ovf=%b want 7/0/1", i, cnt_w, tc_w, ovf_w);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] ec;
    apply_reset();
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      ec = (i < 9) ? 4'(i) : 4'd9;
      checks++;
      if ({cnt_s, tc_s, ovf_s} !== {ec, (i >= 10), (i >= 10)}) begin
        failures++;
        $display("FAIL sat_up step=%0d got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=%b",
                 i, cnt_s, tc_s, ovf_s, ec, (i >= 10), (i >= 10));
      end
    end
    up_dn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      ec = 4'(9 - i);
      checks++;
      if ({cnt_s, tc_s, ovf_s} !== {ec, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL sat_down step=%0d got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=0 ovf=1",
                 i, cnt_s, tc_s, ovf_s, ec);
      end
    end
  endtask

  task automatic test_load_clear();
    apply_reset();
    load = 1'b1; load_value = 4'd12;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_clamp got cnt=%0d tc=%b ovf=%b want 9/0/0", cnt_w, tc_w, ovf_w);
    end
    load = 1'b0; enable = 1'b1; up_dn = 1'b1;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL clamp_then_wrap got cnt=%0d tc=%b ovf=%b want 0/1/1", cnt_w, tc_w, ovf_w);
    end
    enable = 1'b0; load = 1'b1; load_value = 4'd12;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd9, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL load_keeps_ovf got cnt=%0d tc=%b ovf=%b want 9/0/1", cnt_w, tc_w, ovf_w);
    end
    clear = 1'b1; load_value = 4'd5;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_over_load got cnt=%0d tc=%b ovf=%b want 0/0/0", cnt_w, tc_w, ovf_w);
    end
    clear = 1'b0; load = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    enable = 1'b1; up_dn = 1'b0;
    tick();
    enable = 1'b0; load = 1'b1; load_value = 4'd5;
    tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b1;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pre_async got cnt=%0d tc=%b ovf=%b want 6/0/1", cnt_w, tc_w, ovf_w);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_assert got cnt=%0d tc=%b ovf=%b want 0/0/0", cnt_w, tc_w, ovf_w);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_restart got cnt=%0d tc=%b ovf=%b want 1/0/0", cnt_w, tc_w, ovf_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ec;
    apply_reset();
    load = 1'b1; load_value = 4'd3;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      ec = (i % 2 == 0) ? 4'd4 : 4'd3;
      checks++;
      if ({cnt_w, tc_w} !== {ec, 1'b0}) begin
        failures++;
        $display("FAIL dir_toggle step=%0d got cnt=%0d tc=%b want cnt=%0d tc=0", i, cnt_w, tc_w, ec);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_over_count got cnt=%0d tc=%b ovf=%b want 0/0/0", cnt_w, tc_w, ovf_w);
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    apply_reset();
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({cnt_p, tc_p} !== {4'(i / 4), 1'b0}) begin
        failures++;
        $display("FAIL prescale_step cyc=%0d got cnt=%0d tc=%b want cnt=%0d tc=0", i, cnt_p, tc_p, i / 4);
      end
    end
    repeat (2) tick();
    load = 1'b1; load_value = 4'd2;
    tick();
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cnt_p !== ((i == 4) ? 4'd3 : 4'd2)) begin
        failures++;
        $display("FAIL prescale_after_load cyc=%0d got cnt=%0d want %0d", i, cnt_p, (i == 4) ? 3 : 2);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_down();
    test_saturate();
    test_load_clear();
    test_async_reset();
    test_back_to_back();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
